// File: rtl/hamming_pkg.sv
// Shared Hamming(7,4) definitions: FSM states, codeword positions, decoded
// entry layout and the syndrome/correction function.
package hamming_pkg;

    localparam int unsigned HAMMING_N = 7;
    localparam int unsigned HAMMING_K = 4;
    localparam int unsigned SYN_W     = 3;
    localparam int unsigned BIT_CNT_W = 3;

    // Codeword bit index = Hamming position - 1
    localparam int unsigned POS_P1 = 0;
    localparam int unsigned POS_P2 = 1;
    localparam int unsigned POS_D0 = 2;
    localparam int unsigned POS_P4 = 3;
    localparam int unsigned POS_D1 = 4;
    localparam int unsigned POS_D2 = 5;
    localparam int unsigned POS_D3 = 6;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        DECODE = 2'd2
    } state_e;

    typedef struct packed {
        logic [HAMMING_K-1:0] data;
        logic [SYN_W-1:0]     syndrome;
        logic                 corrected;
    } dec_t;

    localparam int unsigned DEC_W = $bits(dec_t);

    // Syndrome points directly at the Hamming position in error
    function automatic dec_t hamming_decode(input logic [HAMMING_N-1:0] code);
        logic [SYN_W-1:0]     syn;
        logic [HAMMING_N-1:0] fixed;
        dec_t                 res;
        syn[0] = code[POS_P1] ^ code[POS_D0] ^ code[POS_D1] ^ code[POS_D3];
        syn[1] = code[POS_P2] ^ code[POS_D0] ^ code[POS_D2] ^ code[POS_D3];
        syn[2] = code[POS_P4] ^ code[POS_D1] ^ code[POS_D2] ^ code[POS_D3];
        fixed  = code;
        if (syn != '0) begin
            fixed[syn - SYN_W'(1)] = ~fixed[syn - SYN_W'(1)];
        end
        res.data      = {fixed[POS_D3], fixed[POS_D2], fixed[POS_D1], fixed[POS_D0]};
        res.syndrome  = syn;
        res.corrected = (syn != '0);
        return res;
    endfunction

endpackage

// File: rtl/hamming_rx_deser_if.sv
// Serial codeword input and decoded-entry valid/ready output of hamming_rx_deser.
interface hamming_rx_deser_if;
    import hamming_pkg::*;

    logic                 ser_in;
    logic                 ser_valid;
    logic                 sof;
    logic [HAMMING_K-1:0] m_data;
    logic [SYN_W-1:0]     m_syndrome;
    logic                 m_corrected;
    logic                 m_valid;
    logic                 m_ready;

    // master: the deserializer itself; slave: line driver plus consumer
    modport master (
        input  ser_in, ser_valid, sof, m_ready,
        output m_data, m_syndrome, m_corrected, m_valid
    );

    modport slave (
        output ser_in, ser_valid, sof, m_ready,
        input  m_data, m_syndrome, m_corrected, m_valid
    );

endinterface

// File: rtl/hamming_rx_fifo2.sv
// Two-entry synchronous FIFO; a push while full is accepted only alongside a pop.
module hamming_rx_fifo2
    import hamming_pkg::*;
#(
    parameter int unsigned W = DEC_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o
);

    logic [W-1:0] mem_q [2];
    logic         rd_ptr_q, rd_ptr_d;
    logic         wr_ptr_q, wr_ptr_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         do_push_c, do_pop_c;

    assign do_pop_c  = pop_i && (cnt_q != 2'd0);
    assign do_push_c = push_i && ((cnt_q != 2'd2) || do_pop_c);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (do_push_c) wr_ptr_d = ~wr_ptr_q;
        if (do_pop_c)  rd_ptr_d = ~rd_ptr_q;
        unique case ({do_push_c, do_pop_c})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (do_push_c) mem_q[wr_ptr_q] <= din_i;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign full_o  = (cnt_q == 2'd2);
    assign empty_o = (cnt_q == 2'd0);

endmodule

// File: rtl/hamming_rx_deser.sv
// Serial Hamming(7,4) receiver: deserialize, correct, buffer in a 2-entry FIFO.
// Optional error statistics enabled by defining HAMMING_ERR_STATS_EN.
module hamming_rx_deser
    import hamming_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    hamming_rx_deser_if.master rx,
    input  logic               clr_stats,
    output logic               overflow,
    output logic               abort,
    output logic [CNT_W-1:0]   err_count,
    output logic [CNT_W-1:0]   frame_count
);

    state_e               state_q, state_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [HAMMING_N-1:0] code_q, code_d;
    logic                 abort_q, abort_d;
    logic                 overflow_q, overflow_d;
    logic                 push_c, pop_c;
    logic                 fifo_full, fifo_empty;
    dec_t                 dec_c, head;

    assign dec_c = hamming_decode(code_q);

    // Next-state: a sof seen mid-frame restarts collection at bit 0
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        code_d    = code_q;
        abort_d   = 1'b0;
        push_c    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rx.ser_valid && rx.sof) begin
                    code_d[POS_P1] = rx.ser_in;
                    bit_cnt_d      = BIT_CNT_W'(1);
                    state_d        = SHIFT;
                end
            end
            SHIFT: begin
                if (rx.ser_valid) begin
                    if (rx.sof) begin
                        abort_d        = 1'b1;
                        code_d[POS_P1] = rx.ser_in;
                        bit_cnt_d      = BIT_CNT_W'(1);
                    end else begin
                        code_d[bit_cnt_q] = rx.ser_in;
                        if (bit_cnt_q == BIT_CNT_W'(HAMMING_N - 1)) begin
                            bit_cnt_d = '0;
                            state_d   = DECODE;
                        end else begin
                            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                        end
                    end
                end
            end
            DECODE: begin
                push_c  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign pop_c      = !fifo_empty && rx.m_ready;
    assign overflow_d = push_c && fifo_full && !pop_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            code_q     <= '0;
            abort_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            code_q     <= code_d;
            abort_q    <= abort_d;
            overflow_q <= overflow_d;
        end
    end

    hamming_rx_fifo2 #(.W(DEC_W)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_c),
        .pop_i   (pop_c),
        .din_i   (dec_c),
        .dout_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign rx.m_data      = head.data;
    assign rx.m_syndrome  = head.syndrome;
    assign rx.m_corrected = head.corrected;
    assign rx.m_valid     = !fifo_empty;
    assign overflow       = overflow_q;
    assign abort          = abort_q;

`ifdef HAMMING_ERR_STATS_EN
    logic [CNT_W-1:0] err_q, err_d;
    logic [CNT_W-1:0] frame_q, frame_d;

    // Saturating counters; clear wins over a same-cycle decode
    always_comb begin
        err_d   = err_q;
        frame_d = frame_q;
        if (clr_stats) begin
            err_d   = '0;
            frame_d = '0;
        end else if (push_c) begin
            if (frame_q != '1) frame_d = frame_q + CNT_W'(1);
            if (dec_c.corrected && (err_q != '1)) err_d = err_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q   <= '0;
            frame_q <= '0;
        end else begin
            err_q   <= err_d;
            frame_q <= frame_d;
        end
    end

    assign err_count   = err_q;
    assign frame_count = frame_q;
`else
    logic unused_clr_stats;
    assign unused_clr_stats = clr_stats;
    assign err_count        = '0;
    assign frame_count      = '0;
`endif

endmodule

// File: tb/tb_hamming_rx_deser.sv
// Directed bench for hamming_rx_deser with a scoreboard of expected decoded entries.
module tb_hamming_rx_deser;
    import hamming_pkg::*;

    localparam int unsigned CNT_W   = 4;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             clr_stats;
    logic             overflow;
    logic             abort;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] frame_count;

    hamming_rx_deser_if bus();

    hamming_rx_deser #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx          (bus),
        .clr_stats   (clr_stats),
        .overflow    (overflow),
        .abort       (abort),
        .err_count   (err_count),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_pops = 0;
    int   exp_frames = 0;
    int   exp_errs = 0;
    logic abort_s0, abort_s1;
    dec_t sb_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] encode(input logic [3:0] d);
        return {d[3], d[2], d[1], d[1] ^ d[2] ^ d[3], d[0], d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3]};
    endfunction

    function automatic logic [6:0] corrupt(input logic [6:0] c, input int flip);
        logic [6:0] r;
        r = c;
        if (flip >= 0) r[flip] = ~r[flip];
        return r;
    endfunction

    function automatic dec_t expect_of(input logic [3:0] d, input int flip);
        dec_t e;
        e.data      = d;
        e.syndrome  = (flip < 0) ? 3'd0 : 3'(flip + 1);
        e.corrected = (flip >= 0);
        return e;
    endfunction

    function automatic int stat_exp(input int v);
`ifdef HAMMING_ERR_STATS_EN
        return v;
`else
        return 0 * v;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [6:0] code, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            bus.ser_valid = 1'b1;
            bus.sof       = (i == 0);
            bus.ser_in    = code[i];
            tick();
            if (i == 0) abort_s0 = abort;
            if (i == 1) abort_s1 = abort;
        end
        bus.ser_valid = 1'b0;
        bus.sof       = 1'b0;
        bus.ser_in    = 1'b0;
    endtask

    // Returns during the DECODE cycle (one ns after the last-bit edge)
    task automatic send_frame(input logic [3:0] d, input int flip, input bit expect_push);
        send_bits(corrupt(encode(d), flip), 7);
        if (expect_push) sb_q.push_back(expect_of(d, flip));
        if (exp_frames < CNT_MAX) exp_frames++;
        if (flip >= 0 && exp_errs < CNT_MAX) exp_errs++;
    endtask

    task automatic check_stats(input string tag);
        check({tag, "_err_count"},   32'(err_count),   32'(stat_exp(exp_errs)));
        check({tag, "_frame_count"}, 32'(frame_count), 32'(stat_exp(exp_frames)));
    endtask

    // Scoreboard: every accepted pop must match the oldest expected entry
    always @(negedge clk) begin
        if (rst_n && bus.m_valid && bus.m_ready) begin
            n_pops++;
            check("sb_nonempty", 32'(sb_q.size() != 0), 32'(1));
            if (sb_q.size() != 0) begin
                dec_t e;
                e = sb_q.pop_front();
                check("sb_data",      32'(bus.m_data),      32'(e.data));
                check("sb_syndrome",  32'(bus.m_syndrome),  32'(e.syndrome));
                check("sb_corrected", 32'(bus.m_corrected), 32'(e.corrected));
            end
        end
    end

    initial begin
        int p0;
        rst_n         = 1'b0;
        clr_stats     = 1'b0;
        bus.ser_in    = 1'b0;
        bus.ser_valid = 1'b0;
        bus.sof       = 1'b0;
        bus.m_ready   = 1'b0;
        repeat (3) tick();

        check("rst_m_valid",     32'(bus.m_valid),     32'(0));
        check("rst_m_data",      32'(bus.m_data),      32'(0));
        check("rst_m_syndrome",  32'(bus.m_syndrome),  32'(0));
        check("rst_m_corrected", 32'(bus.m_corrected), 32'(0));
        check("rst_overflow",    32'(overflow),        32'(0));
        check("rst_abort",       32'(abort),           32'(0));
        check_stats("rst");
        rst_n = 1'b1;
        tick();
        tick();

        // Clean frame, consumer stalled: latency and hold
        send_frame(4'b1011, -1, 1'b1);
        check("t1_valid_at_E", 32'(bus.m_valid), 32'(0));
        tick();
        check("t1_valid_at_E1", 32'(bus.m_valid),     32'(1));
        check("t1_data",        32'(bus.m_data),      32'(4'b1011));
        check("t1_syndrome",    32'(bus.m_syndrome),  32'(0));
        check("t1_corrected",   32'(bus.m_corrected), 32'(0));
        tick();
        tick();
        check("t1_hold_valid", 32'(bus.m_valid), 32'(1));
        check("t1_hold_data",  32'(bus.m_data),  32'(4'b1011));
        bus.m_ready = 1'b1;
        tick();
        tick();
        check("t1_drained", 32'(bus.m_valid), 32'(0));

        // Single-bit error at code[4]
        send_frame(4'b1011, 4, 1'b1);
        tick();
        check("t2_syndrome",  32'(bus.m_syndrome),  32'(3'b101));
        check("t2_data",      32'(bus.m_data),      32'(4'b1011));
        check("t2_corrected", 32'(bus.m_corrected), 32'(1));
        tick();
        check_stats("t2");

        // Three frames into a stalled buffer: third is dropped
        bus.m_ready = 1'b0;
        send_frame(4'h3, -1, 1'b1);
        tick();
        send_frame(4'h9, 2, 1'b1);
        tick();
        send_frame(4'h6, -1, 1'b0);
        check("t3_ovf_before", 32'(overflow), 32'(0));
        tick();
        check("t3_ovf_pulse", 32'(overflow),    32'(1));
        check("t3_head",      32'(bus.m_data),  32'(4'h3));
        tick();
        check("t3_ovf_after", 32'(overflow), 32'(0));
        check_stats("t3");
        p0 = n_pops;
        bus.m_ready = 1'b1;
        for (int k = 0; k < 10 && bus.m_valid; k++) tick();
        check("t3_drain_valid", 32'(bus.m_valid),  32'(0));
        check("t3_drain_pops",  32'(n_pops - p0),  32'(2));
        check("t3_sb_empty",    32'(sb_q.size()),  32'(0));

        // sof after four bits aborts the partial frame
        p0 = n_pops;
        send_bits(encode(4'hC), 4);
        send_frame(4'h5, 6, 1'b1);
        check("t4_abort_pulse", 32'(abort_s0), 32'(1));
        check("t4_abort_clear", 32'(abort_s1), 32'(0));
        tick();
        tick();
        check("t4_one_entry", 32'(n_pops - p0), 32'(1));
        check_stats("t4");

        // Reset mid-frame with one entry buffered
        bus.m_ready = 1'b0;
        send_frame(4'hA, -1, 1'b0);
        tick();
        check("t5_buffered", 32'(bus.m_valid), 32'(1));
        send_bits(encode(4'h7), 3);
        rst_n      = 1'b0;
        exp_frames = 0;
        exp_errs   = 0;
        #1;
        check("t5_rst_valid", 32'(bus.m_valid),     32'(0));
        check("t5_rst_data",  32'(bus.m_data),      32'(0));
        check("t5_rst_state", 32'(dut.state_q),     32'(IDLE));
        check("t5_rst_cnt",   32'(dut.bit_cnt_q),   32'(0));
        check_stats("t5_rst");
        tick();
        rst_n = 1'b1;
        tick();
        bus.m_ready = 1'b1;
        send_frame(4'hE, 0, 1'b1);
        tick();
        tick();
        check("t5_sb_empty", 32'(sb_q.size()), 32'(0));
        check_stats("t5");

        // Random data and error positions at full rate
        for (int k = 0; k < 8; k++) begin
            send_frame(4'($urandom_range(0, 15)), int'($urandom_range(0, 7)) - 1, 1'b1);
            tick();
        end
        tick();
        check("t6_sb_empty", 32'(sb_q.size()), 32'(0));

        // Counter saturation, then clear racing a decode
        for (int k = 0; k < 16; k++) begin
            send_frame(4'($urandom_range(0, 15)), 3, 1'b1);
            tick();
        end
        check_stats("t7_sat");
        send_frame(4'h1, 5, 1'b1);
        tick();
        check_stats("t7_hold");
        send_frame(4'h2, 5, 1'b1);
        clr_stats = 1'b1;
        tick();
        clr_stats  = 1'b0;
        exp_frames = 0;
        exp_errs   = 0;
        check_stats("t7_clr");

        repeat (3) tick();
        check("end_sb_empty", 32'(sb_q.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hamming_rx_deser.md
# hamming_rx_deser

Serial receive front-end feeding the Hamming(7,4) decode path. It gathers a 7-bit codeword one bit per strobe, computes the syndrome and corrects any single-bit error. It then delivers the 4-bit data nibble, syndrome and correction flag through a 2-entry valid/ready output buffer. It sits between the channel/line interface and the consumers of decoded data, and keeps optional error statistics.

## Interface
- CNT_W, 16, width of the statistics counters (≥2)
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- ser_in  in  1  serial codeword bit
- ser_valid  in  1  ser_in is valid this cycle
- sof  in  1  start of frame; qualified by ser_valid, marks bit 0
- m_data  out  4  corrected data nibble {d3,d2,d1,d0}
- m_syndrome  out  3  raw syndrome {s4,s2,s1}
- m_corrected  out  1  syndrome was non-zero and one bit was flipped
- m_valid  out  1  output entry available
- m_ready  in  1  consumer accepts entry
- overflow  out  1  one-cycle pulse: decoded frame dropped, buffer full
- abort  out  1  one-cycle pulse: partial frame discarded by new sof
- clr_stats  in  1  synchronous clear of statistics counters
- err_count  out  CNT_W  frames decoded with non-zero syndrome, saturating
- frame_count  out  CNT_W  frames decoded (including dropped), saturating

## Operation
- Codeword bit order, LSB first on the wire:
  - code[0]=p1, code[1]=p2, code[2]=d0, code[3]=p4, code[4]=d1, code[5]=d2, code[6]=d3.
  - code[i] is Hamming position i+1.
- Syndrome:
  - s1 = ^code[0,2,4,6]
  - s2 = ^code[1,2,5,6]
  - s4 = ^code[3,4,5,6]
  - When the syndrome s≠0, flip code[s-1].
  - data = {code[6],code[5],code[4],code[2]} after correction.
- FSM states: IDLE, SHIFT, DECODE.
  - IDLE: ser_valid&&sof stores bit 0, bit_cnt=1, moves to SHIFT. ser_valid without sof is ignored.
  - SHIFT: each ser_valid stores ser_in at code[bit_cnt] and increments bit_cnt. The 7th bit (bit_cnt=6) moves to DECODE.
  - SHIFT with ser_valid&&sof: pulse abort, restart (bit 0 = ser_in, bit_cnt=1), stay in SHIFT.
  - DECODE (exactly one cycle): correct, then push {data,syndrome,corrected} to the buffer, return to IDLE. ser_valid and sof are ignored here; upstream guarantees ≥1 idle cycle between frames.
- Push in DECODE:
  - Accepted if the buffer holds <2 entries, or holds 2 and a pop occurs the same cycle.
  - Otherwise the frame is dropped and overflow pulses.
- Pop: m_valid&&m_ready. The buffer is FIFO ordered and m_* shows the oldest entry.
- Reset values:
  - FSM=IDLE, bit_cnt=0, buffer empty.
  - m_valid=0; m_data, m_syndrome, m_corrected = 0.
  - overflow=0, abort=0, counters=0.
- Reset asserted mid-frame or with entries buffered discards everything immediately.

## Timing
- Last bit sampled at edge E. FSM is in DECODE during cycle E→E+1, the entry is written at E+1, and m_valid is high after E+1.
- With an empty buffer, m_data is stable from E+1 until popped.
- Minimum frame period is 8 cycles (7 bits + DECODE). Sustained throughput is one nibble per 8 cycles when m_ready is held high.
- m_valid, once high, stays high with m_data stable until popped. It does not depend combinationally on m_ready.
- Push and pop in the same cycle at 1 entry: count stays 1, and the new entry is visible the next cycle.
- overflow and abort are registered pulses, high for exactly the cycle after the triggering edge.

## Configuration
- HAMMING_ERR_STATS_EN defined:
  - frame_count increments on every DECODE.
  - err_count increments on DECODE with syndrome≠0.
  - Both saturate at all-ones.
  - clr_stats zeroes both and takes priority over an increment in the same cycle.
- Not defined:
  - Counter logic is absent; err_count and frame_count are tied to 0 and clr_stats is ignored.
  - Ports remain present so the interface is unchanged.

## Structure
- Shared package hamming_pkg holds:
  - FSM state enum (IDLE/SHIFT/DECODE).
  - Codeword position constants.
  - Syndrome and correction function returning {data,syndrome,corrected}.
  - HAMMING_N=7 and HAMMING_K=4 constants.
- One sub-module, hamming_rx_fifo2: 2-entry synchronous FIFO, width 8, with push/pop/full/empty, same clk and rst_n.

## Test plan
- Clean frame, data 4'b1011 → codeword 7'b1010101 sent LSB-first → m_data=1011, m_syndrome=000, m_corrected=0, m_valid 2 edges after last bit.
- Same codeword with code[4] flipped → m_syndrome=101, m_data=1011, m_corrected=1, err_count=1 (macro on).
- Three back-to-back frames, m_ready=0 → first two buffered; third pulses overflow and is dropped, frame_count=3. Then raise m_ready → 2 pops in order, m_valid falls.
- sof reasserted after 4 bits → abort pulse; new frame decodes correctly and only 1 entry is produced.
- rst_n asserted at bit 3 with 1 entry buffered → m_valid=0, state IDLE immediately. The next full frame decodes normally.
- Macro on, err_count at all-ones plus an error frame → stays all-ones. clr_stats together with an error frame → 0.
